// File: rtl/kitchen_pkg.sv
// Shared definitions for the kitchen stations: item-word field codes, station
// indices, station state encoding and item-word transforms.
package kitchen_pkg;

  localparam int ITEM_W   = 12;
  localparam int FIELD_W  = 3;
  localparam int N_FIELDS = 4;

  localparam int CHICKEN_LSB = 9;
  localparam int TOMATO_LSB  = 6;
  localparam int RICE_LSB    = 3;
  localparam int ONION_LSB   = 0;
  localparam int FIELD_LSB [N_FIELDS] = '{CHICKEN_LSB, TOMATO_LSB, RICE_LSB, ONION_LSB};

  localparam logic [FIELD_W-1:0] FLD_ABSENT = 3'b000;
  localparam logic [FIELD_W-1:0] FLD_RAW    = 3'b100;
  localparam logic [FIELD_W-1:0] FLD_CHOP   = 3'b010;
  localparam logic [FIELD_W-1:0] FLD_COOK   = 3'b001;
  localparam logic [FIELD_W-1:0] FLD_BURNT  = 3'b111;

  localparam logic [1:0] ST_STOVE1 = 2'd0;
  localparam logic [1:0] ST_STOVE2 = 2'd1;
  localparam logic [1:0] ST_CHOP   = 2'd2;
  localparam logic [1:0] ST_SERVE  = 2'd3;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_PROC  = 2'b01,
    S_READY = 2'b10,
    S_BURNT = 2'b11
  } station_state_t;

  typedef logic [ITEM_W-1:0] item_t;

  function automatic logic has_field(input item_t item, input logic [FIELD_W-1:0] code);
    logic hit;
    hit = 1'b0;
    for (int f = 0; f < N_FIELDS; f++)
      if (item[FIELD_LSB[f] +: FIELD_W] == code) hit = 1'b1;
    return hit;
  endfunction

  function automatic item_t xform_field(input item_t item,
                                        input logic [FIELD_W-1:0] from_code,
                                        input logic [FIELD_W-1:0] to_code);
    item_t res;
    res = item;
    for (int f = 0; f < N_FIELDS; f++)
      if (item[FIELD_LSB[f] +: FIELD_W] == from_code) res[FIELD_LSB[f] +: FIELD_W] = to_code;
    return res;
  endfunction

  // Every ingredient present, whatever its stage, turns to burnt.
  function automatic item_t burn_item(input item_t item);
    item_t res;
    res = item;
    for (int f = 0; f < N_FIELDS; f++)
      if (item[FIELD_LSB[f] +: FIELD_W] != FLD_ABSENT) res[FIELD_LSB[f] +: FIELD_W] = FLD_BURNT;
    return res;
  endfunction

endpackage

// File: rtl/station_fsm.sv
// One processing station: holds an item, times PROC on ticks, and for stoves
// times the cooked item towards BURNT.
module station_fsm
  import kitchen_pkg::*;
#(
  parameter int               PROC_TICKS = 20,
  parameter int               BURN_TICKS = 30,
  parameter bit               BURN_EN    = 1'b0,
  parameter logic [FIELD_W-1:0] FROM_CODE = FLD_RAW,
  parameter logic [FIELD_W-1:0] TO_CODE   = FLD_CHOP,
  parameter int               CNT_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           load_en,
  input  item_t          load_item,
  input  logic           take_en,
  output item_t          item,
  output station_state_t state,
  output logic           done_pulse,
  output logic           burnt_pulse
);

  localparam logic [CNT_W-1:0] PROC_LAST = CNT_W'(PROC_TICKS - 1);
  localparam logic [CNT_W-1:0] BURN_LAST = CNT_W'(BURN_TICKS - 1);

  logic [CNT_W-1:0] cnt;
  logic             cooked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      item        <= '0;
      state       <= S_EMPTY;
      cnt         <= '0;
      cooked      <= 1'b0;
      done_pulse  <= 1'b0;
      burnt_pulse <= 1'b0;
    end else begin
      done_pulse  <= 1'b0;
      burnt_pulse <= 1'b0;
      // Requests take priority over the time base; a same-cycle tick is dropped.
      if (take_en) begin
        item   <= '0;
        state  <= S_EMPTY;
        cnt    <= '0;
        cooked <= 1'b0;
      end else if (load_en) begin
        item   <= load_item;
        cnt    <= '0;
        cooked <= 1'b0;
        state  <= has_field(load_item, FROM_CODE) ? S_PROC : S_READY;
      end else if (tick) begin
        case (state)
          S_PROC: begin
            if (cnt == PROC_LAST) begin
              item       <= xform_field(item, FROM_CODE, TO_CODE);
              state      <= S_READY;
              cnt        <= '0;
              cooked     <= BURN_EN;
              done_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_READY: begin
            if (BURN_EN && cooked) begin
              if (cnt == BURN_LAST) begin
                item        <= burn_item(item);
                state       <= S_BURNT;
                cnt         <= '0;
                cooked      <= 1'b0;
                burnt_pulse <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/station_process_scheduler.sv
// Arbitrates put-down / pick-up requests across the kitchen stations and
// runs the serve hatch; stoves and chop board are station_fsm instances.
module station_process_scheduler
  import kitchen_pkg::*;
#(
  parameter int CHOP_TICKS = 20,
  parameter int COOK_TICKS = 50,
  parameter int BURN_TICKS = 30,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        load_req,
  input  logic [1:0]  load_sel,
  input  logic [11:0] load_item,
  input  logic        take_req,
  input  logic [1:0]  take_sel,
  output logic        load_ack,
  output logic        load_nack,
  output logic        take_ack,
  output logic        take_nack,
  output logic [11:0] take_item,
  output logic [47:0] station_item,
  output logic [7:0]  station_state,
  output logic [3:0]  done_pulse,
  output logic [1:0]  burnt_pulse,
  output logic        serve_valid,
  output logic [11:0] serve_item
);

  item_t          st_item [4];
  station_state_t st_st   [4];
  logic [2:0]     load_en, take_en, done;
  logic           load_ok, take_ok, serve_load;
  logic           chop_burnt_unused;

  // The serve hatch passes items straight through and always reads as empty.
  assign st_item[3] = '0;
  assign st_st[3]   = S_EMPTY;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    take_ok    = 1'b0;
    load_ok    = 1'b0;
    take_en    = '0;
    load_en    = '0;
    take_ok    = take_req && (st_st[take_sel] == S_READY || st_st[take_sel] == S_BURNT);
    // A take on the same station is evaluated first and always blocks the load.
    load_ok    = load_req && (load_item != '0) && (st_st[load_sel] == S_EMPTY) &&
                 !(take_req && (take_sel == load_sel));
    for (int i = 0; i < 3; i++) begin
      take_en[i] = take_ok && (take_sel == 2'(i));
      load_en[i] = load_ok && (load_sel == 2'(i));
    end
    serve_load = load_ok && (load_sel == ST_SERVE);
  end

  station_fsm #(
    .PROC_TICKS(COOK_TICKS), .BURN_TICKS(BURN_TICKS), .BURN_EN(1'b1),
    .FROM_CODE(FLD_CHOP), .TO_CODE(FLD_COOK), .CNT_W(CNT_W)
  ) u_stove_1 (
    .clk, .rst, .tick,
    .load_en(load_en[ST_STOVE1]), .load_item, .take_en(take_en[ST_STOVE1]),
    .item(st_item[0]), .state(st_st[0]),
    .done_pulse(done[0]), .burnt_pulse(burnt_pulse[0])
  );

  station_fsm #(
    .PROC_TICKS(COOK_TICKS), .BURN_TICKS(BURN_TICKS), .BURN_EN(1'b1),
    .FROM_CODE(FLD_CHOP), .TO_CODE(FLD_COOK), .CNT_W(CNT_W)
  ) u_stove_2 (
    .clk, .rst, .tick,
    .load_en(load_en[ST_STOVE2]), .load_item, .take_en(take_en[ST_STOVE2]),
    .item(st_item[1]), .state(st_st[1]),
    .done_pulse(done[1]), .burnt_pulse(burnt_pulse[1])
  );

  station_fsm #(
    .PROC_TICKS(CHOP_TICKS), .BURN_TICKS(BURN_TICKS), .BURN_EN(1'b0),
    .FROM_CODE(FLD_RAW), .TO_CODE(FLD_CHOP), .CNT_W(CNT_W)
  ) u_chop (
    .clk, .rst, .tick,
    .load_en(load_en[ST_CHOP]), .load_item, .take_en(take_en[ST_CHOP]),
    .item(st_item[2]), .state(st_st[2]),
    .done_pulse(done[2]), .burnt_pulse(chop_burnt_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_ack    <= 1'b0;
      load_nack   <= 1'b0;
      take_ack    <= 1'b0;
      take_nack   <= 1'b0;
      take_item   <= '0;
      serve_valid <= 1'b0;
      serve_item  <= '0;
    end else begin
      load_ack    <= load_req && load_ok;
      load_nack   <= load_req && !load_ok;
      take_ack    <= take_ok;
      take_nack   <= take_req && !take_ok;
      take_item   <= take_ok ? st_item[take_sel] : '0;
      serve_valid <= serve_load;
      if (serve_load) serve_item <= load_item;
    end
  end

  assign station_item  = {st_item[3], st_item[2], st_item[1], st_item[0]};
  assign station_state = {st_st[3], st_st[2], st_st[1], st_st[0]};
  assign done_pulse    = {1'b0, done};

endmodule

// File: tb/tb_station_process_scheduler.sv
// Self-checking bench for station_process_scheduler: request responses and
// served items go through scoreboard queues, station contents are checked directly.
module tb_station_process_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        load_req = 1'b0;
  logic [1:0]  load_sel = '0;
  logic [11:0] load_item = '0;
  logic        take_req = 1'b0;
  logic [1:0]  take_sel = '0;
  logic        load_ack, load_nack, take_ack, take_nack;
  logic [11:0] take_item;
  logic [47:0] station_item;
  logic [7:0]  station_state;
  logic [3:0]  done_pulse;
  logic [1:0]  burnt_pulse;
  logic        serve_valid;
  logic [11:0] serve_item;

  station_process_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick),
    .load_req(load_req), .load_sel(load_sel), .load_item(load_item),
    .take_req(take_req), .take_sel(take_sel),
    .load_ack(load_ack), .load_nack(load_nack),
    .take_ack(take_ack), .take_nack(take_nack), .take_item(take_item),
    .station_item(station_item), .station_state(station_state),
    .done_pulse(done_pulse), .burnt_pulse(burnt_pulse),
    .serve_valid(serve_valid), .serve_item(serve_item)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        la;
    logic        ln;
    logic        ta;
    logic        tn;
    logic [11:0] ti;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [11:0] serve_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  d_early;
  logic [1:0]  b_early;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rsp_t rsp(input logic la, input logic ln, input logic ta,
                               input logic tn, input logic [11:0] ti);
    rsp_t r;
    r.la = la; r.ln = ln; r.ta = ta; r.tn = tn; r.ti = ti;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request cycle; the expected response is queued when driven and popped when it appears.
  task automatic drive(input string tag, input logic l, input logic [1:0] ls, input logic [11:0] li,
                       input logic t, input logic [1:0] ts, input rsp_t exp);
    rsp_t e;
    load_req = l; load_sel = ls; load_item = li;
    take_req = t; take_sel = ts;
    rsp_q.push_back(exp);
    if (l && ls == 2'd3 && exp.la) serve_q.push_back(li);
    step();
    load_req = 1'b0; take_req = 1'b0; load_item = '0;
    e = rsp_q.pop_front();
    check(tag, 48'({load_ack, load_nack, take_ack, take_nack, take_item}), 48'(e));
  endtask

  // n consecutive ticks; pulses seen before the last one are returned so early firing is caught.
  task automatic run_ticks(input int n, output logic [3:0] d, output logic [1:0] b);
    d = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      if (i < n - 1) begin
        d |= done_pulse;
        b |= burnt_pulse;
      end
    end
    tick = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (serve_valid) begin
      if (serve_q.size() == 0) check("serve_unexpected", 48'(serve_valid), 48'(0));
      else check("serve_item", 48'(serve_item), 48'(serve_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    check("reset_outputs", 48'({load_ack, load_nack, take_ack, take_nack, take_item,
                                done_pulse, burnt_pulse, serve_valid, serve_item}), 48'(0));
    rst = 1'b0;
    step();
    check("reset_items", station_item, 48'(0));
    check("reset_states", 48'(station_state), 48'(0));

    // Chop: raw chicken becomes chopped on the 20th tick.
    drive("t1_load_chop", 1'b1, 2'd2, 12'h800, 1'b0, 2'd0, rsp(1, 0, 0, 0, 12'h000));
    check("t1_chop_proc", 48'(station_state[5:4]), 48'(2'b01));
    run_ticks(20, d_early, b_early);
    check("t1_no_early_done", 48'(d_early), 48'(0));
    check("t1_done", 48'(done_pulse), 48'(4'b0100));
    check("t1_chop_item", 48'(station_item[35:24]), 48'(12'h400));
    check("t1_chop_ready", 48'(station_state[5:4]), 48'(2'b10));
    step();
    check("t1_done_one_cycle", 48'(done_pulse), 48'(0));

    // Stove 1: cook after 50 ticks, burn 30 ticks later, then pick up.
    drive("t2_load_stove1", 1'b1, 2'd0, 12'h400, 1'b0, 2'd0, rsp(1, 0, 0, 0, 12'h000));
    check("t2_stove1_proc", 48'(station_state[1:0]), 48'(2'b01));
    run_ticks(50, d_early, b_early);
    check("t2_no_early_done", 48'(d_early), 48'(0));
    check("t2_done", 48'(done_pulse), 48'(4'b0001));
    check("t2_cooked_item", 48'(station_item[11:0]), 48'(12'h200));
    check("t2_stove1_ready", 48'(station_state[1:0]), 48'(2'b10));
    run_ticks(30, d_early, b_early);
    check("t2_no_early_burn", 48'({d_early, b_early}), 48'(0));
    check("t2_burnt_pulse", 48'(burnt_pulse), 48'(2'b01));
    check("t2_burnt_item", 48'(station_item[11:0]), 48'(12'hE00));
    check("t2_stove1_burnt", 48'(station_state[1:0]), 48'(2'b11));
    check("t2_chop_untouched", 48'({station_state[5:4], station_item[35:24]}), 48'({2'b10, 12'h400}));
    drive("t2_take_stove1", 1'b0, 2'd0, 12'h000, 1'b1, 2'd0, rsp(0, 0, 1, 0, 12'hE00));
    check("t2_stove1_empty", 48'({station_state[1:0], station_item[11:0]}), 48'(0));

    // Busy and empty-hand rejections.
    drive("t3_load_stove2", 1'b1, 2'd1, 12'h400, 1'b0, 2'd0, rsp(1, 0, 0, 0, 12'h000));
    drive("t3_load_busy", 1'b1, 2'd1, 12'h010, 1'b0, 2'd0, rsp(0, 1, 0, 0, 12'h000));
    drive("t3_take_proc", 1'b0, 2'd0, 12'h000, 1'b1, 2'd1, rsp(0, 0, 0, 1, 12'h000));
    check("t3_stove2_kept", 48'({station_state[3:2], station_item[23:12]}), 48'({2'b01, 12'h400}));
    drive("t3_take_chop", 1'b0, 2'd0, 12'h000, 1'b1, 2'd2, rsp(0, 0, 1, 0, 12'h400));
    drive("t3_load_zero", 1'b1, 2'd2, 12'h000, 1'b0, 2'd0, rsp(0, 1, 0, 0, 12'h000));
    check("t3_chop_empty", 48'({station_state[5:4], station_item[35:24]}), 48'(0));

    // Same-station take+load: take wins, load nacked; different stations: both proceed.
    drive("t4_load_cooked", 1'b1, 2'd0, 12'h208, 1'b0, 2'd0, rsp(1, 0, 0, 0, 12'h000));
    check("t4_direct_ready", 48'(station_state[1:0]), 48'(2'b10));
    drive("t4_same_station", 1'b1, 2'd0, 12'h100, 1'b1, 2'd0, rsp(0, 1, 1, 0, 12'h208));
    check("t4_stove1_empty", 48'({station_state[1:0], station_item[11:0]}), 48'(0));
    drive("t4_load_s1", 1'b1, 2'd0, 12'h001, 1'b0, 2'd0, rsp(1, 0, 0, 0, 12'h000));
    drive("t4_diff_station", 1'b1, 2'd2, 12'h104, 1'b1, 2'd0, rsp(1, 0, 1, 0, 12'h001));
    check("t4_states", 48'({station_state[5:4], station_state[1:0]}), 48'({2'b01, 2'b00}));

    // Serve hatch.
    drive("t5_load_serve", 1'b1, 2'd3, 12'h249, 1'b0, 2'd0, rsp(1, 0, 0, 0, 12'h000));
    check("t5_serve_valid", 48'(serve_valid), 48'(1));
    step();
    check("t5_after_serve", 48'({station_state[7:6], serve_valid, serve_item}), 48'({2'b00, 1'b0, 12'h249}));

    // Asynchronous reset halfway through a chop.
    run_ticks(10, d_early, b_early);
    check("t6_chop_midway", 48'({d_early, done_pulse, station_state[5:4]}), 48'({4'b0, 4'b0, 2'b01}));
    #3 rst = 1'b1;
    #1;
    check("t6_async_items", station_item, 48'(0));
    check("t6_async_outputs", 48'({station_state, load_ack, take_ack, take_item, serve_valid, serve_item}), 48'(0));
    repeat (2) step();
    rst = 1'b0;
    run_ticks(25, d_early, b_early);
    check("t6_no_done", 48'({d_early, b_early, done_pulse, burnt_pulse}), 48'(0));
    check("t6_states_empty", 48'(station_state), 48'(0));

    check("serve_q_drained", 48'(serve_q.size()), 48'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/station_process_scheduler.md
Name: station_process_scheduler

Overview:
- Sequences the kitchen stations: stove_1, stove_2, chop, serve.
- Accepts put-down and pick-up requests from the player-inventory logic, holds each station's 12-bit item word, and runs per-station processing timers.
- Timers turn raw to chopped (chop), chopped to cooked (stoves), and cooked to burnt if a stove item is left too long.
- Sits between the button/switch front end and the display/scoring logic.

Parameters:
- CHOP_TICKS, 20, ticks for the chop station to finish processing.
- COOK_TICKS, 50, ticks for a stove to finish cooking.
- BURN_TICKS, 30, ticks a cooked stove item may sit in READY before it burns.
- CNT_W, 8, timer counter width; must hold max(CHOP_TICKS, COOK_TICKS, BURN_TICKS).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle time-base strobe from the prescaler.
- load_req  in  1  put-down request.
- load_sel  in  2  target station: 0 stove_1, 1 stove_2, 2 chop, 3 serve.
- load_item  in  12  item word being put down.
- take_req  in  1  pick-up request.
- take_sel  in  2  source station, same encoding as load_sel.
- load_ack  out  1  put-down accepted (registered pulse).
- load_nack  out  1  put-down rejected (registered pulse).
- take_ack  out  1  pick-up accepted (registered pulse).
- take_nack  out  1  pick-up rejected (registered pulse).
- take_item  out  12  item returned on take_ack; 0 otherwise.
- station_item  out  48  contents of stations 3..0, 12 bits each, station 0 in the LSBs.
- station_state  out  8  2-bit state per station, station 0 in the LSBs.
- done_pulse  out  4  one-cycle pulse when a station enters READY from PROC.
- burnt_pulse  out  2  one-cycle pulse when a stove enters BURNT.
- serve_valid  out  1  one-cycle pulse when an item is served.
- serve_item  out  12  item served; held until the next serve.

Behaviour:
- Item word:
  - Four 3-bit fields: [11:9] chicken, [8:6] tomato, [5:3] rice, [2:0] onion.
  - Field codes: 000 absent, 100 raw, 010 chopped, 001 cooked, 111 burnt.
  - Item word 0 means an empty hand; a load of 0 is nacked.
- Reset: all station_item 0, all states EMPTY, all counters 0, every pulse 0, take_item 0, serve_item 0.
- States (2 bits): EMPTY=00, PROC=01, READY=10, BURNT=11.
- Chop station:
  - Load in EMPTY: if any field is 100, go to PROC with counter=0; otherwise go straight to READY.
  - In PROC, the counter increments on tick.
  - On the tick where counter reaches CHOP_TICKS-1: every 100 field becomes 010, state goes to READY, done_pulse[2] fires.
- Stoves:
  - Load in EMPTY: if any field is 010, go to PROC; otherwise go to READY with cooked_flag=0.
  - PROC lasts COOK_TICKS ticks, then every 010 field becomes 001 (raw fields are untouched), state goes to READY, cooked_flag=1, done_pulse fires.
  - READY with cooked_flag=1 counts ticks; after BURN_TICKS ticks, every nonzero field becomes 111, state goes to BURNT, burnt_pulse fires.
- Serve station:
  - Load in EMPTY: next cycle serve_valid=1, serve_item=item, station returns to EMPTY.
  - The station never holds contents visibly for more than 1 cycle.
- Load rules:
  - Accepted only if the target is EMPTY and load_item != 0.
  - Otherwise load_nack fires and no state changes.
- Take rules:
  - Accepted in READY or BURNT: take_item = contents, station goes to EMPTY, counter and flag clear.
  - Rejected in EMPTY or PROC.
- Response timing: all ack/nack pulses and take_item appear exactly 1 cycle after the request cycle and last 1 cycle.
- Simultaneous load and take:
  - Different stations: both are processed in the same cycle.
  - Same station: take is evaluated first and load is nacked, even if the take empties the station.
- tick coinciding with load/take on the same station: the request wins and the tick is ignored for that station.
- Counter saturation: counters never wrap; they reset to 0 on every state change.
- Reset mid-PROC: immediate return to the reset values above; no done_pulse is emitted.

Decomposition:
- Shared package kitchen_pkg:
  - Field codes FLD_ABSENT/RAW/CHOP/COOK/BURNT.
  - Station indices ST_STOVE1, ST_STOVE2, ST_CHOP, ST_SERVE.
  - State encodings and field slice positions.
  - Function xform_field(item, from_code, to_code).
- Sub-module station_fsm (parameters PROC_TICKS, BURN_EN, FROM_CODE, TO_CODE):
  - Instantiated 3 times (stove_1, stove_2, chop).
  - The serve logic and request arbitration stay in the top level.

Test Plan:
1. Reset, then load 12'h800 (raw chicken) to chop and pulse 20 ticks -> load_ack at +1 cycle; state PROC; after 20th tick done_pulse[2]=1, station_item[35:24]=12'h400, state READY.
2. Load 12'h400 to stove_1, 50 ticks -> item 12'h200, done_pulse[0]; continue 30 ticks -> item 12'hE00, burnt_pulse[0], state BURNT; take -> take_ack, take_item=12'hE00, state EMPTY.
3. Load to stove_2 while PROC, then take from stove_2 while PROC -> load_nack and take_nack, contents unchanged; load 12'h000 to empty chop -> load_nack.
4. Stove_1 READY holding 12'h208; same cycle take_sel=0 and load_sel=0 with 12'h100 -> take_ack with 12'h208, load_nack, stove_1 EMPTY.
5. Load 12'h249 to serve -> next cycle serve_valid=1, serve_item=12'h249, load_ack=1; following cycle station 3 state EMPTY.
6. Assert rst asynchronously at chop tick 10 of 20 -> all outputs 0 immediately; no done_pulse after release.
